// File: rtl/cache_access_ctrl.sv
// cache_access_ctrl
//   Load/store front-end that sits between the MEM pipeline stage and the data
//   cache port. It handles one access at a time. For each access it:
//     - word-aligns the address,
//     - builds the byte mask and the lane-replicated store data,
//     - issues the cache request and waits for completion,
//     - hands the captured read word, offset, size and signedness to an
//       external sign-extend block,
//     - returns that block's result to the pipeline.
//
//   Optional feature macro: CACHE_ACCESS_CTRL_MISALIGN_TRAP_EN
//     defined   : a misaligned HALF/WORD request never reaches the cache. It
//                 answers directly with resp_fault=1 and resp_data=0.
//     undefined : resp_fault is tied 0. Misaligned accesses are issued with a
//                 truncated lane: HALF uses off[1], WORD ignores the offset.
//
//   Ports
//     clk_i, reset_i          clock, async active-high reset
//     req_*                   pipeline request (valid/ready handshake)
//     cache_*                 data cache request / completion
//     se_data/offset/signed/size -> sign-extend block, se_result <- it
//     resp_*                  pipeline response (valid/ready handshake)
//
//   FSM states
//     S_IDLE  | ready for a request (req_ready=1)
//     S_ISSUE | cache_valid=1, cache_* held until cache_ready
//     S_WAIT  | request accepted by cache, waiting for cache_done
//     S_RESP  | resp_valid=1 until resp_ready
`timescale 1ns/1ps

package cache_access_pkg;
  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } cache_access_size_t;
endpackage

module cache_access_ctrl
  import cache_access_pkg::*;
#(
  parameter  int ADDR_SIZE   = 32,
  parameter  int WORD_SIZE   = 32,
  localparam int OFFSET_SIZE = $clog2(WORD_SIZE/8),
  localparam int MASK_SIZE   = WORD_SIZE/8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_SIZE-1:0]   req_addr,
  input  logic                   req_wr,
  input  cache_access_size_t     req_size,
  input  logic                   req_signed,
  input  logic [WORD_SIZE-1:0]   req_wdata,
  output logic                   cache_valid,
  input  logic                   cache_ready,
  output logic [ADDR_SIZE-1:0]   cache_addr,
  output logic                   cache_wr,
  output logic [MASK_SIZE-1:0]   cache_wmask,
  output logic [WORD_SIZE-1:0]   cache_wdata,
  input  logic                   cache_done,
  input  logic [WORD_SIZE-1:0]   cache_rdata,
  output logic [WORD_SIZE-1:0]   se_data,
  output logic [OFFSET_SIZE-1:0] se_offset,
  output logic                   se_signed,
  output cache_access_size_t     se_size,
  input  logic [WORD_SIZE-1:0]   se_result,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WORD_SIZE-1:0]   resp_data,
  output logic                   resp_fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_RESP  = 2'b11
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                   w_accept;
  logic                   w_capture;
  logic                   w_misalign;
  logic                   w_fault;
  logic [OFFSET_SIZE-1:0] w_off;
  logic [ADDR_SIZE-1:0]   w_addr_aligned;
  logic [MASK_SIZE-1:0]   w_mask;
  logic [WORD_SIZE-1:0]   w_wdata;

  logic [ADDR_SIZE-1:0]   r_cache_addr;
  logic                   r_cache_wr;
  logic [MASK_SIZE-1:0]   r_cache_wmask;
  logic [WORD_SIZE-1:0]   r_cache_wdata;
  logic [WORD_SIZE-1:0]   r_se_data;
  logic [OFFSET_SIZE-1:0] r_se_offset;
  logic                   r_se_signed;
  cache_access_size_t     r_se_size;

  // Request datapath: byte lane and alignment
  assign w_off          = req_addr[OFFSET_SIZE-1:0];
  assign w_addr_aligned = {req_addr[ADDR_SIZE-1:OFFSET_SIZE], {OFFSET_SIZE{1'b0}}};

  always_comb begin
    w_mask  = '1;
    w_wdata = req_wdata;
    case (req_size)
      BYTE: begin
        w_mask  = MASK_SIZE'(1) << w_off;
        w_wdata = {MASK_SIZE{req_wdata[7:0]}};
      end
      HALF: begin
        // The low offset bit is dropped, so a misaligned half stays inside its half-word lane.
        w_mask  = MASK_SIZE'(3) << {w_off[OFFSET_SIZE-1:1], 1'b0};
        w_wdata = {(MASK_SIZE/2){req_wdata[15:0]}};
      end
      default: begin
        w_mask  = '1;
        w_wdata = req_wdata;
      end
    endcase
  end

`ifdef CACHE_ACCESS_CTRL_MISALIGN_TRAP_EN
  logic r_fault;

  always_comb begin
    w_misalign = 1'b0;
    case (req_size)
      HALF:    w_misalign = w_off[0];
      WORD:    w_misalign = (w_off != '0);
      default: w_misalign = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_fault <= w_misalign;
    end else if (resp_valid && resp_ready) begin
      r_fault <= 1'b0;
    end
  end

  assign w_fault = r_fault;
`else
  assign w_misalign = 1'b0;
  assign w_fault    = 1'b0;
`endif

  // FSM
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    req_ready   = 1'b0;
    cache_valid = 1'b0;
    resp_valid  = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = w_misalign ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        cache_valid = 1'b1;
        if (cache_ready) begin
          // A cache that completes in the accept cycle skips WAIT.
          if (cache_done) begin
            w_capture = 1'b1;
            w_next    = S_RESP;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cache_done) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Access registers: loaded at accept and held until the next accept.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cache_addr  <= '0;
      r_cache_wr    <= 1'b0;
      r_cache_wmask <= '0;
      r_cache_wdata <= '0;
      r_se_data     <= '0;
      r_se_offset   <= '0;
      r_se_signed   <= 1'b0;
      r_se_size     <= BYTE;
    end else begin
      if (w_accept) begin
        r_cache_addr  <= w_addr_aligned;
        r_cache_wr    <= req_wr;
        r_cache_wmask <= req_wr ? w_mask : '0;
        r_cache_wdata <= req_wr ? w_wdata : '0;
        r_se_offset   <= w_off;
        r_se_signed   <= req_signed & ~req_wr;
        r_se_size     <= req_size;
      end
      if (w_capture && !r_cache_wr) begin
        r_se_data <= cache_rdata;
      end
    end
  end

  assign cache_addr  = r_cache_addr;
  assign cache_wr    = r_cache_wr;
  assign cache_wmask = r_cache_wmask;
  assign cache_wdata = r_cache_wdata;
  assign se_data     = r_se_data;
  assign se_offset   = r_se_offset;
  assign se_signed   = r_se_signed;
  assign se_size     = r_se_size;

  // Stores and faulted accesses return zero.
  assign resp_data  = (resp_valid && !r_cache_wr && !w_fault) ? se_result : '0;
  assign resp_fault = resp_valid && w_fault;

endmodule

// File: tb/tb_cache_access_ctrl.sv
`timescale 1ns/1ps

module tb_cache_access_ctrl;
  import cache_access_pkg::*;

  logic               clk_i = 1'b0;
  logic               reset_i;
  logic               req_valid;
  logic               req_ready;
  logic [31:0]        req_addr;
  logic               req_wr;
  cache_access_size_t req_size;
  logic               req_signed;
  logic [31:0]        req_wdata;
  logic               cache_valid;
  logic               cache_ready;
  logic [31:0]        cache_addr;
  logic               cache_wr;
  logic [3:0]         cache_wmask;
  logic [31:0]        cache_wdata;
  logic               cache_done;
  logic [31:0]        cache_rdata;
  logic [31:0]        se_data;
  logic [1:0]         se_offset;
  logic               se_signed;
  cache_access_size_t se_size;
  logic [31:0]        se_result;
  logic               resp_valid;
  logic               resp_ready;
  logic [31:0]        resp_data;
  logic               resp_fault;

  cache_access_ctrl dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_wr      (req_wr),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_wdata   (req_wdata),
    .cache_valid (cache_valid),
    .cache_ready (cache_ready),
    .cache_addr  (cache_addr),
    .cache_wr    (cache_wr),
    .cache_wmask (cache_wmask),
    .cache_wdata (cache_wdata),
    .cache_done  (cache_done),
    .cache_rdata (cache_rdata),
    .se_data     (se_data),
    .se_offset   (se_offset),
    .se_signed   (se_signed),
    .se_size     (se_size),
    .se_result   (se_result),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_fault  (resp_fault)
  );

  always #5 clk_i = ~clk_i;

  // Reference sign-extend block standing in for the downstream unit.
  logic [31:0] tb_sh;
  always_comb begin
    tb_sh     = '0;
    se_result = se_data;
    case (se_size)
      BYTE: begin
        tb_sh     = se_data >> {se_offset, 3'b000};
        se_result = se_signed ? {{24{tb_sh[7]}}, tb_sh[7:0]} : {24'h0, tb_sh[7:0]};
      end
      HALF: begin
        tb_sh     = se_data >> {se_offset[1], 4'b0000};
        se_result = se_signed ? {{16{tb_sh[15]}}, tb_sh[15:0]} : {16'h0, tb_sh[15:0]};
      end
      default: se_result = se_data;
    endcase
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // Observations from the last do_access
  logic        o_cvalid, o_wr, o_sgn, o_rvalid, o_fault;
  logic [31:0] o_addr, o_wdata, o_resp;
  logic [3:0]  o_mask;
  logic [1:0]  o_off;
  cache_access_size_t o_size;

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("wait_idle", {31'h0, req_ready}, 32'h1);
  endtask

  // Entered and left at posedge+1. sc=1: cache_ready and cache_done in the same cycle.
  task automatic do_access(input logic [31:0] a, input logic w, input cache_access_size_t sz,
                           input logic sg, input logic [31:0] wd, input logic [31:0] rd,
                           input bit sc);
    wait_idle();
    req_addr = a; req_wr = w; req_size = sz; req_signed = sg; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk_i); #1;
    req_valid   = 1'b0;
    cache_ready = 1'b1;
    if (sc) begin
      cache_done  = 1'b1;
      cache_rdata = rd;
    end
    @(negedge clk_i);
    o_cvalid = cache_valid; o_addr = cache_addr; o_mask = cache_wmask;
    o_wdata  = cache_wdata; o_wr = cache_wr; o_off = se_offset;
    o_size   = se_size; o_sgn = se_signed;
    @(posedge clk_i); #1;
    cache_ready = 1'b0;
    if (!sc) begin
      cache_done  = 1'b1;
      cache_rdata = rd;
      @(posedge clk_i); #1;
    end
    cache_done  = 1'b0;
    cache_rdata = 32'h5555_5555;
    resp_ready  = 1'b1;
    @(negedge clk_i);
    o_rvalid = resp_valid; o_resp = resp_data; o_fault = resp_fault;
    @(posedge clk_i); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int early;
    logic [31:0] last;

    reset_i = 1'b1; req_valid = 1'b0; req_addr = '0; req_wr = 1'b0; req_size = BYTE;
    req_signed = 1'b0; req_wdata = '0; cache_ready = 1'b0; cache_done = 1'b0;
    cache_rdata = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    check("rst_req_ready",   {31'h0, req_ready},   32'h1);
    check("rst_cache_valid", {31'h0, cache_valid}, 32'h0);
    check("rst_resp_valid",  {31'h0, resp_valid},  32'h0);
    check("rst_cache_addr",  cache_addr,           32'h0);
    check("rst_resp_fault",  {31'h0, resp_fault},  32'h0);
    @(posedge clk_i); #1;

    // LW 0x100
    do_access(32'h100, 1'b0, WORD, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    check("lw_cvalid", {31'h0, o_cvalid}, 32'h1);
    check("lw_addr",   o_addr,            32'h100);
    check("lw_wr",     {31'h0, o_wr},     32'h0);
    check("lw_mask",   {28'h0, o_mask},   32'h0);
    check("lw_rvalid", {31'h0, o_rvalid}, 32'h1);
    check("lw_resp",   o_resp,            32'hDEAD_BEEF);

    // LB signed / LBU at 0x103
    do_access(32'h103, 1'b0, BYTE, 1'b1, 32'h0, 32'h80FF_0000, 1'b0);
    check("lb_addr", o_addr,           32'h100);
    check("lb_off",  {30'h0, o_off},   32'h3);
    check("lb_sgn",  {31'h0, o_sgn},   32'h1);
    check("lb_resp", o_resp,           32'hFFFF_FF80);
    do_access(32'h103, 1'b0, BYTE, 1'b0, 32'h0, 32'h80FF_0000, 1'b0);
    check("lbu_resp", o_resp,          32'h0000_0080);

    // LBU 0x101, cache ready and done together
    do_access(32'h101, 1'b0, BYTE, 1'b0, 32'h0, 32'h0000_AB00, 1'b1);
    check("sc_rvalid", {31'h0, o_rvalid}, 32'h1);
    check("sc_resp",   o_resp,            32'h0000_00AB);

    // SH 0x206
    do_access(32'h206, 1'b1, HALF, 1'b1, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
    check("sh_addr",  o_addr,          32'h204);
    check("sh_wr",    {31'h0, o_wr},   32'h1);
    check("sh_mask",  {28'h0, o_mask}, 32'hC);
    check("sh_wdata", o_wdata,         32'h1234_1234);
    check("sh_resp",  o_resp,          32'h0);

    // SB 0x5
    do_access(32'h5, 1'b1, BYTE, 1'b0, 32'h0000_00AA, 32'hFFFF_FFFF, 1'b0);
    check("sb_addr",  o_addr,          32'h4);
    check("sb_mask",  {28'h0, o_mask}, 32'h2);
    check("sb_wdata", o_wdata,         32'hAAAA_AAAA);

`ifdef CACHE_ACCESS_CTRL_MISALIGN_TRAP_EN
    // Misaligned LW traps without touching the cache
    wait_idle();
    req_addr = 32'h102; req_wr = 1'b0; req_size = WORD; req_signed = 1'b0;
    req_valid = 1'b1;
    @(posedge clk_i); #1;
    req_valid = 1'b0;
    @(negedge clk_i);
    check("trap_cvalid", {31'h0, cache_valid}, 32'h0);
    check("trap_rvalid", {31'h0, resp_valid},  32'h1);
    check("trap_fault",  {31'h0, resp_fault},  32'h1);
    check("trap_data",   resp_data,            32'h0);
    resp_ready = 1'b1;
    @(posedge clk_i); #1;
    resp_ready = 1'b0;
    check("trap_fault_clr", {31'h0, resp_fault}, 32'h0);
    check("trap_idle",      {31'h0, req_ready},  32'h1);
`else
    // Misaligned accesses issue with a truncated lane
    do_access(32'h102, 1'b1, WORD, 1'b0, 32'h1122_3344, 32'h0, 1'b0);
    check("msw_addr",  o_addr,             32'h100);
    check("msw_mask",  {28'h0, o_mask},    32'hF);
    check("msw_wdata", o_wdata,            32'h1122_3344);
    check("msw_fault", {31'h0, o_fault},   32'h0);
    do_access(32'h207, 1'b1, HALF, 1'b0, 32'h0000_BEEF, 32'h0, 1'b0);
    check("msh_addr",  o_addr,             32'h204);
    check("msh_mask",  {28'h0, o_mask},    32'hC);
    check("msh_wdata", o_wdata,            32'hBEEF_BEEF);
`endif

    // Cache stalls: ready low 5 cycles, done 3 cycles after accept
    wait_idle();
    req_addr = 32'h300; req_wr = 1'b0; req_size = WORD; req_signed = 1'b0;
    req_valid = 1'b1;
    @(posedge clk_i); #1;
    req_valid = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (cache_valid && cache_addr == 32'h300 && !cache_wr && cache_wmask == 4'h0) cnt++;
    end
    check("stall_stable", cnt, 5);
    cache_ready = 1'b1;
    @(posedge clk_i); #1;
    cache_ready = 1'b0;
    early = 0;
    repeat (2) begin
      @(posedge clk_i); #1;
      if (resp_valid || cache_valid) early++;
    end
    check("stall_early", early, 0);
    @(posedge clk_i); #1;
    cache_done  = 1'b1;
    cache_rdata = 32'hCAFE_F00D;
    @(posedge clk_i); #1;
    cache_done = 1'b0;
    resp_ready = 1'b1;
    cnt = 0; last = '0;
    repeat (6) begin
      @(negedge clk_i);
      if (resp_valid) begin
        cnt++;
        last = resp_data;
      end
    end
    resp_ready = 1'b0;
    check("stall_one_resp", cnt, 1);
    check("stall_data", last, 32'hCAFE_F00D);
    @(posedge clk_i); #1;

    // Response back-pressure: LH signed 0x102, resp_ready low 4 cycles
    wait_idle();
    req_addr = 32'h102; req_wr = 1'b0; req_size = HALF; req_signed = 1'b1;
    req_valid = 1'b1;
    @(posedge clk_i); #1;
    cache_ready = 1'b1; cache_done = 1'b1; cache_rdata = 32'hF00D_1234;
    req_addr = 32'h400; req_size = WORD;   // pending request must not be taken during RESP
    @(posedge clk_i); #1;
    cache_ready = 1'b0; cache_done = 1'b0; cache_rdata = '0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (resp_valid && resp_data == 32'hFFFF_F00D && !req_ready && !cache_valid) cnt++;
    end
    check("hold_cycles", cnt, 4);
    check("hold_se_size", 32'(se_size), 32'(HALF));
    check("hold_se_off",  {30'h0, se_offset}, 32'h2);
    resp_ready = 1'b1;
    @(posedge clk_i); #1;
    resp_ready = 1'b0;
    check("hold_idle",   {31'h0, req_ready},   32'h1);
    check("hold_no_iss", {31'h0, cache_valid}, 32'h0);
    req_valid = 1'b0;

    // Reset during ISSUE: cache_valid drops without a clock edge
    wait_idle();
    req_addr = 32'h500; req_wr = 1'b0; req_size = WORD;
    req_valid = 1'b1;
    @(posedge clk_i); #1;
    req_valid = 1'b0;
    @(negedge clk_i);
    check("rsti_cvalid_pre", {31'h0, cache_valid}, 32'h1);
    #1 reset_i = 1'b1;
    #1;
    check("rsti_cvalid", {31'h0, cache_valid}, 32'h0);
    check("rsti_ready",  {31'h0, req_ready},   32'h1);
    @(posedge clk_i); #1;
    reset_i = 1'b0;

    // Reset during WAIT: late cache_done produces no response
    wait_idle();
    req_addr = 32'h600; req_wr = 1'b0; req_size = WORD;
    req_valid = 1'b1;
    @(posedge clk_i); #1;
    req_valid = 1'b0; cache_ready = 1'b1;
    @(posedge clk_i); #1;
    cache_ready = 1'b0;
    @(negedge clk_i);
    #1 reset_i = 1'b1;
    #1;
    check("rstw_rvalid", {31'h0, resp_valid}, 32'h0);
    check("rstw_ready",  {31'h0, req_ready},  32'h1);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    cache_done = 1'b1; cache_rdata = 32'h1357_9BDF;
    @(posedge clk_i); #1;
    cache_done = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (resp_valid || cache_valid || !req_ready) cnt++;
    end
    check("rstw_no_resp", cnt, 0);
    @(posedge clk_i); #1;

    // Normal access after reset recovery
    do_access(32'h40, 1'b0, WORD, 1'b0, 32'h0, 32'h0123_4567, 1'b0);
    check("rec_addr", o_addr, 32'h40);
    check("rec_resp", o_resp, 32'h0123_4567);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
